// File: rtl/mb_regfile_mp.sv
// mb_regfile_mp: parametrised multi-port register file slice with registered
// reads, per-port read-valid strobes, a carry-chained counter mode and a
// sticky write-collision flag.
// Optional feature macro: MB_REGFILE_BYPASS_EN (same-cycle write-to-read
// forwarding). Undefined by default: reads return pre-write content.
module mb_regfile_mp #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int NPORTS = 4,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        wr_en,
  input  logic [NPORTS*AW-1:0]     wr_addr,
  input  logic [NPORTS*WIDTH-1:0]  wr_data,
  input  logic [NPORTS-1:0]        rd_en,
  input  logic [NPORTS*AW-1:0]     rd_addr,
  output logic [NPORTS*WIDTH-1:0]  rd_data,
  output logic [NPORTS-1:0]        rd_vld,
  input  logic                     cnt_en,
  input  logic [AW-1:0]            cnt_addr,
  input  logic                     cnt_dn,
  input  logic                     ci,
  output logic                     co,
  output logic                     err
);

  logic [WIDTH-1:0]        mem     [DEPTH];
  logic [WIDTH-1:0]        mem_nxt [DEPTH];
  logic [WIDTH-1:0]        wr_val  [DEPTH];
  logic [DEPTH-1:0]        wr_hit;
  logic                    coll;
  logic [WIDTH:0]          cnt_sum;
  logic                    cnt_live;
  logic [NPORTS*WIDTH-1:0] rd_data_nxt;

  // Resolve port writes per register: ascending scan, first hit (lowest port) wins,
  // any later hit on an already-claimed register is a collision.
  always_comb begin
    wr_hit = '0;
    coll   = 1'b0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      wr_val[a] = '0;
    end
    for (int unsigned a = 0; a < DEPTH; a++) begin
      for (int unsigned p = 0; p < NPORTS; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == AW'(a))) begin
          if (wr_hit[a]) begin
            coll = 1'b1;
          end else begin
            wr_hit[a] = 1'b1;
            wr_val[a] = wr_data[p*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // Counter arithmetic with one extra bit capturing carry (up) or borrow (down);
  // a port write to the same register cancels the counter op.
  always_comb begin
    if (cnt_dn) begin
      cnt_sum = {1'b0, mem[cnt_addr]} - {{WIDTH{1'b0}}, ci};
    end else begin
      cnt_sum = {1'b0, mem[cnt_addr]} + {{WIDTH{1'b0}}, ci};
    end
    cnt_live = cnt_en && !wr_hit[cnt_addr];
    for (int unsigned a = 0; a < DEPTH; a++) begin
      if (wr_hit[a]) begin
        mem_nxt[a] = wr_val[a];
      end else if (cnt_live && (cnt_addr == AW'(a))) begin
        mem_nxt[a] = cnt_sum[WIDTH-1:0];
      end else begin
        mem_nxt[a] = mem[a];
      end
    end
  end

  // Read mux: disabled ports return zero rather than holding the last value.
  always_comb begin
    rd_data_nxt = '0;
    for (int unsigned p = 0; p < NPORTS; p++) begin
      if (rd_en[p]) begin
`ifdef MB_REGFILE_BYPASS_EN
        rd_data_nxt[p*WIDTH +: WIDTH] = mem_nxt[rd_addr[p*AW +: AW]];
`else
        rd_data_nxt[p*WIDTH +: WIDTH] = mem[rd_addr[p*AW +: AW]];
`endif
      end
    end
  end

  // State register: storage, registered read ports, carry out and sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        mem[a] <= '0;
      end
      rd_data <= '0;
      rd_vld  <= '0;
      co      <= 1'b0;
      err     <= 1'b0;
    end else begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        mem[a] <= mem_nxt[a];
      end
      rd_data <= rd_data_nxt;
      rd_vld  <= rd_en;
      co      <= cnt_live && cnt_sum[WIDTH];
      err     <= err || coll;
    end
  end

endmodule

// File: tb/tb_mb_regfile_mp.sv
// tb_mb_regfile_mp: table-driven bench for mb_regfile_mp (default 4x4, 4 ports)
// with a scoreboard queue of expected outputs popped one cycle after drive.
module tb_mb_regfile_mp;
  localparam int W  = 4;
  localparam int D  = 4;
  localparam int NP = 4;
  localparam int A  = 2;

`ifdef MB_REGFILE_BYPASS_EN
  localparam logic [15:0] RW_EXP = 16'h9000;
`else
  localparam logic [15:0] RW_EXP = 16'h2000;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NP-1:0]  wr_en = '0;
  logic [NP*A-1:0] wr_addr = '0;
  logic [NP*W-1:0] wr_data = '0;
  logic [NP-1:0]  rd_en = '0;
  logic [NP*A-1:0] rd_addr = '0;
  logic [NP*W-1:0] rd_data;
  logic [NP-1:0]  rd_vld;
  logic           cnt_en = 1'b0;
  logic [A-1:0]   cnt_addr = '0;
  logic           cnt_dn = 1'b0;
  logic           ci = 1'b0;
  logic           co;
  logic           err;

  mb_regfile_mp #(.WIDTH(W), .DEPTH(D), .NPORTS(NP)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_vld(rd_vld),
    .cnt_en(cnt_en), .cnt_addr(cnt_addr), .cnt_dn(cnt_dn), .ci(ci),
    .co(co), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  v;
    logic        co;
    logic        err;
    string       name;
  } exp_t;

  typedef struct {
    logic [3:0]  we;
    logic [7:0]  wa;
    logic [15:0] wd;
    logic [3:0]  re;
    logic [7:0]  ra;
    logic        ce;
    logic [1:0]  ca;
    logic        cd;
    logic        ci;
    exp_t        x;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [3:0] we, input logic [7:0] wa,
                              input logic [15:0] wd, input logic [3:0] re, input logic [7:0] ra,
                              input logic ce, input logic [1:0] ca, input logic cd, input logic cin,
                              input logic [15:0] xd, input logic [3:0] xv, input logic xco,
                              input logic xerr);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
    v.ce = ce; v.ca = ca; v.cd = cd; v.ci = cin;
    v.x.d = xd; v.x.v = xv; v.x.co = xco; v.x.err = xerr; v.x.name = nm;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    wr_en = v.we; wr_addr = v.wa; wr_data = v.wd;
    rd_en = v.re; rd_addr = v.ra;
    cnt_en = v.ce; cnt_addr = v.ca; cnt_dn = v.cd; ci = v.ci;
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    drive(v);
    sb.push_back(v.x);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, " rd_data"}, 32'(rd_data), 32'(e.d));
    chk({e.name, " rd_vld"},  32'(rd_vld),  32'(e.v));
    chk({e.name, " co"},      32'(co),      32'(e.co));
    chk({e.name, " err"},     32'(err),     32'(e.err));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " rd_data"}, 32'(rd_data), 32'h0);
    chk({nm, " rd_vld"},  32'(rd_vld),  32'h0);
    chk({nm, " co"},      32'(co),      32'h0);
    chk({nm, " err"},     32'(err),     32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  m [4];
    logic [7:0]  wa;
    logic [15:0] wd;
    logic [15:0] xd;
    int          ns [4];
    ns = '{0, 3, 10, 19};

    #12;
    chk_zero("reset");
    reset = 1'b0;

    // Reset read-out on all ports, then idle cycle.
    apply(mk("rd_all", 4'h0, 8'h00, 16'h0, 4'hF, 8'hE4, 1'b0, 2'd0, 1'b0, 1'b0,
             16'h0000, 4'hF, 1'b0, 1'b0));
    apply(mk("idle", 4'h0, 8'h00, 16'h0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0,
             16'h0000, 4'h0, 1'b0, 1'b0));

    // Rotating write pattern, each register read back on every port.
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 4; r++) begin
        wa = '0;
        wd = '0;
        for (int p = 0; p < 4; p++) begin
          wa[p*2 +: 2] = 2'((p + r) % 4);
          wd[p*4 +: 4] = 4'((ns[i] + p) & 15);
        end
        apply(mk("rot_wr", 4'hF, wa, wd, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0,
                 16'h0000, 4'h0, 1'b0, 1'b0));
        for (int p = 0; p < 4; p++) m[(p + r) % 4] = 4'((ns[i] + p) & 15);
        for (int a = 0; a < 4; a++) begin
          xd = {m[a], m[a], m[a], m[a]};
          wa = {2'(a), 2'(a), 2'(a), 2'(a)};
          apply(mk("rot_rd", 4'h0, 8'h00, 16'h0, 4'hF, wa, 1'b0, 2'd0, 1'b0, 1'b0,
                   xd, 4'hF, 1'b0, 1'b0));
        end
      end
    end

    reset = 1'b1;
    #2;
    reset = 1'b0;

    // Counter sequence on reg 1.
    tbl.push_back(mk("cnt_init", 4'h1, 8'h01, 16'h000E, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0,
                     16'h0000, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk("cnt_up_e", 4'h0, 8'h00, 16'h0, 4'h1, 8'h01, 1'b1, 2'd1, 1'b0, 1'b1,
                     16'h000E, 4'h1, 1'b0, 1'b0));
    tbl.push_back(mk("cnt_up_f", 4'h0, 8'h00, 16'h0, 4'h1, 8'h01, 1'b1, 2'd1, 1'b0, 1'b1,
                     16'h000F, 4'h1, 1'b1, 1'b0));
    tbl.push_back(mk("cnt_dn_0", 4'h0, 8'h00, 16'h0, 4'h1, 8'h01, 1'b1, 2'd1, 1'b1, 1'b1,
                     16'h0000, 4'h1, 1'b1, 1'b0));
    tbl.push_back(mk("cnt_ci0", 4'h0, 8'h00, 16'h0, 4'h1, 8'h01, 1'b1, 2'd1, 1'b1, 1'b0,
                     16'h000F, 4'h1, 1'b0, 1'b0));
    tbl.push_back(mk("cnt_hold", 4'h0, 8'h00, 16'h0, 4'h1, 8'h01, 1'b0, 2'd0, 1'b0, 1'b0,
                     16'h000F, 4'h1, 1'b0, 1'b0));
    // Counter vs port write on reg 0.
    tbl.push_back(mk("cnt_vs_wr", 4'h1, 8'h00, 16'h0007, 4'h0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1,
                     16'h0000, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk("cnt_vs_rd", 4'h0, 8'h00, 16'h0, 4'h4, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0,
                     16'h0700, 4'h4, 1'b0, 1'b0));
    // Same-cycle read and write of reg 3.
    tbl.push_back(mk("rw_init", 4'h2, 8'h0C, 16'h0020, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0,
                     16'h0000, 4'h0, 1'b0, 1'b0));
    tbl.push_back(mk("rw_same", 4'h1, 8'h03, 16'h0009, 4'h8, 8'hC0, 1'b0, 2'd0, 1'b0, 1'b0,
                     RW_EXP, 4'h8, 1'b0, 1'b0));
    tbl.push_back(mk("rw_after", 4'h0, 8'h00, 16'h0, 4'h8, 8'hC0, 1'b0, 2'd0, 1'b0, 1'b0,
                     16'h9000, 4'h8, 1'b0, 1'b0));
    // Collision: ports 1 and 3 on reg 2.
    tbl.push_back(mk("coll_wr", 4'hA, 8'h88, 16'hA050, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0,
                     16'h0000, 4'h0, 1'b0, 1'b1));
    tbl.push_back(mk("coll_rd", 4'h0, 8'h00, 16'h0, 4'hF, 8'hAA, 1'b0, 2'd0, 1'b0, 1'b0,
                     16'h5555, 4'hF, 1'b0, 1'b1));
    tbl.push_back(mk("coll_stky", 4'h0, 8'h00, 16'h0, 4'h0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0,
                     16'h0000, 4'h0, 1'b0, 1'b1));
    // Counter wrap on reg 1 (still 0xF) so co is high going into the reset.
    tbl.push_back(mk("pre_rst", 4'h0, 8'h00, 16'h0, 4'hF, 8'hAA, 1'b1, 2'd1, 1'b0, 1'b1,
                     16'h5555, 4'hF, 1'b1, 1'b1));

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset mid-cycle while a write and a read are being driven.
    drive(mk("rst_mid", 4'h1, 8'h02, 16'h0003, 4'hF, 8'hAA, 1'b1, 2'd1, 1'b0, 1'b1,
             16'h0, 4'h0, 1'b0, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    chk_zero("rst_async");
    @(posedge clk);
    #2;
    reset = 1'b0;
    apply(mk("rst_after", 4'h0, 8'h00, 16'h0, 4'hF, 8'hE4, 1'b0, 2'd0, 1'b0, 1'b0,
             16'h0000, 4'hF, 1'b0, 1'b0));

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
